// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg: memory-map constants, region decode and scanner state type for hack_mmio_memory.
package hack_mem_pkg;
    localparam int DEF_RAM_WORDS    = 16384;
    localparam int DEF_SCREEN_WORDS = 8192;
    localparam int DEF_SCREEN_BASE  = DEF_RAM_WORDS;
    localparam int DEF_KBD_ADDR     = DEF_RAM_WORDS + DEF_SCREEN_WORDS;

    typedef enum logic [1:0] {REG_RAM, REG_SCREEN, REG_KBD, REG_NONE} region_e;
    typedef enum logic [1:0] {SCAN_IDLE, SCAN_RUN, SCAN_DRAIN} scan_state_e;

    function automatic region_e decode(input int unsigned a, input int unsigned ram_words,
                                       input int unsigned screen_words);
        return (a < ram_words) ? REG_RAM :
               (a < ram_words + screen_words) ? REG_SCREEN :
               (a == ram_words + screen_words) ? REG_KBD : REG_NONE;
    endfunction
endpackage

// File: rtl/hack_screen_scanner.sv
// hack_screen_scanner: walks the screen buffer and presents words on a ready/valid stream.
module hack_screen_scanner
    import hack_mem_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int SCREEN_WORDS = 8192,
    parameter int AW           = $clog2(SCREEN_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_scan_en,
    input  logic              i_pix_ready,
    output logic [AW-1:0]     o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [DATA_W-1:0] o_pix_data,
    output logic              o_pix_valid,
    output logic              o_pix_sof
);
    scan_state_e       r_state;
    logic [AW-1:0]     r_ptr;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_sof;
    logic              w_fetch;

    // Fetching straight from IDLE gives the one-cycle latency after scan_en rises.
    assign w_fetch     = i_scan_en && (r_state != SCAN_DRAIN) && (!r_valid || i_pix_ready);
    assign o_rd_addr   = r_ptr;
    assign o_pix_data  = r_data;
    assign o_pix_valid = r_valid;
    assign o_pix_sof   = r_sof;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SCAN_IDLE;
            r_ptr   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
        end else if (w_fetch) begin
            r_state <= SCAN_RUN;
            r_data  <= i_rd_data;
            r_valid <= 1'b1;
            r_sof   <= (r_ptr == '0);
            r_ptr   <= (r_ptr == AW'(SCREEN_WORDS - 1)) ? '0 : r_ptr + AW'(1);
        end else if (r_state == SCAN_RUN && !i_scan_en) begin
            r_state <= (r_valid && !i_pix_ready) ? SCAN_DRAIN : SCAN_IDLE;
            r_valid <= r_valid && !i_pix_ready;
        end else if (r_state == SCAN_DRAIN && i_pix_ready) begin
            r_state <= SCAN_IDLE;
            r_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/hack_mmio_memory.sv
// hack_mmio_memory: Hack data-memory map (RAM, screen, keyboard) with error flag and screen scan-out port.
module hack_mmio_memory
    import hack_mem_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 15,
    parameter int RAM_WORDS    = DEF_RAM_WORDS,
    parameter int SCREEN_WORDS = DEF_SCREEN_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              load,
    output logic [DATA_W-1:0] out,
    output logic              addr_err,
    input  logic [DATA_W-1:0] kbd_code,
    input  logic              scan_en,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof
);
    localparam int SCREEN_BASE = RAM_WORDS;
    localparam int KBD_ADDR    = RAM_WORDS + SCREEN_WORDS;
    localparam int RAM_AW      = $clog2(RAM_WORDS);
    localparam int SCR_AW      = $clog2(SCREEN_WORDS);

    if (KBD_ADDR >= 2 ** ADDR_W) begin : g_bad_map
        $error("hack_mmio_memory: keyboard address does not fit in ADDR_W");
    end

    logic [DATA_W-1:0] r_ram    [RAM_WORDS];
    logic [DATA_W-1:0] r_screen [SCREEN_WORDS];
    logic [DATA_W-1:0] r_kbd;
    logic              r_addr_err;
    region_e           w_region;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [SCR_AW-1:0] w_scr_idx;
    logic [SCR_AW-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;

    assign w_region  = decode(32'(addr), RAM_WORDS, SCREEN_WORDS);
    assign w_ram_idx = addr[RAM_AW-1:0];
    assign w_scr_idx = SCR_AW'(addr - ADDR_W'(SCREEN_BASE));
    assign w_rd_data = r_screen[w_rd_addr];
    assign addr_err  = r_addr_err;
    assign out = (w_region == REG_RAM)    ? r_ram[w_ram_idx] :
                 (w_region == REG_SCREEN) ? r_screen[w_scr_idx] :
                 (w_region == REG_KBD)    ? r_kbd : '0;

    // Memories are never cleared; reset only blocks a coincident write.
    always_ff @(posedge clk) begin
        if (!reset && load && w_region == REG_RAM) r_ram[w_ram_idx] <= in;
        if (!reset && load && w_region == REG_SCREEN) r_screen[w_scr_idx] <= in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_kbd      <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_kbd      <= kbd_code;
            r_addr_err <= (w_region == REG_NONE);
        end
    end

    hack_screen_scanner #(
        .DATA_W      (DATA_W),
        .SCREEN_WORDS(SCREEN_WORDS),
        .AW          (SCR_AW)
    ) u_scanner (
        .clk        (clk),
        .reset      (reset),
        .i_scan_en  (scan_en),
        .i_pix_ready(pix_ready),
        .o_rd_addr  (w_rd_addr),
        .i_rd_data  (w_rd_data),
        .o_pix_data (pix_data),
        .o_pix_valid(pix_valid),
        .o_pix_sof  (pix_sof)
    );
endmodule

// File: tb/tb_hack_mmio_memory.sv
// tb_hack_mmio_memory: scoreboard bench for the CPU port, error flag and screen scan-out (default and 4-word screen).
module tb_hack_mmio_memory;
    logic        clk = 1'b0, reset = 1'b1, load = 1'b0;
    logic        scan_en = 1'b0, pix_ready = 1'b0, s_scan_en = 1'b0, s_pix_ready = 1'b0;
    logic [15:0] in = '0, kbd_code = '0;
    logic [14:0] addr = '0;
    logic [15:0] out, pix_data, s_out, s_pix_data;
    logic        addr_err, pix_valid, pix_sof, s_addr_err, s_pix_valid, s_pix_sof;
    int          tests = 0, fails = 0;
    logic [15:0] cq[$];
    logic [16:0] sq[$];

    always #5 clk = ~clk;

    hack_mmio_memory dut (
        .clk(clk), .reset(reset), .in(in), .addr(addr), .load(load), .out(out),
        .addr_err(addr_err), .kbd_code(kbd_code), .scan_en(scan_en), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof)
    );

    hack_mmio_memory #(.SCREEN_WORDS(4)) dut_s (
        .clk(clk), .reset(reset), .in(in), .addr(addr), .load(load), .out(s_out),
        .addr_err(s_addr_err), .kbd_code(kbd_code), .scan_en(s_scan_en), .pix_data(s_pix_data),
        .pix_valid(s_pix_valid), .pix_ready(s_pix_ready), .pix_sof(s_pix_sof)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [14:0] a, input logic [15:0] d);
        addr = a;
        in   = d;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] e;
        kbd_code = 16'h1234;
        addr     = 15'h6000;
        reset    = 1'b1;
        tick();
        tick();
        @(negedge clk);
        tests++;
        if (out !== 16'h0000 || addr_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_cpu: out=%h addr_err=%b, required out=0000 addr_err=0", out, addr_err);
        end
        tests++;
        if (pix_valid !== 1'b0 || pix_sof !== 1'b0 || pix_data !== 16'h0000) begin
            fails++;
            $display("FAIL reset_scan: valid=%b sof=%b data=%h, required 0 0 0000", pix_valid, pix_sof, pix_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cq.push_back(16'h1234);
        tick();
        @(negedge clk);
        e = cq.pop_front();
        tests++;
        if (out !== e) begin
            fails++;
            $display("FAIL kbd_capture: out=%h required %h", out, e);
        end
        tick();
    endtask

    task automatic test_ram;
        logic [14:0] a_t [3] = '{15'h0000, 15'h21A7, 15'h3FFF};
        logic [15:0] d_t [3] = '{16'd2, 16'd9, 16'd1};
        logic [15:0] e;
        for (int i = 0; i < 3; i++) cpu_write(a_t[i], d_t[i]);
        for (int i = 0; i < 3; i++) begin
            addr = a_t[i];
            cq.push_back(d_t[i]);
            @(negedge clk);
            e = cq.pop_front();
            tests++;
            if (out !== e) begin
                fails++;
                $display("FAIL ram_read[%h]: out=%h required %h", a_t[i], out, e);
            end
            tick();
        end
    endtask

    task automatic test_screen_kbd;
        logic [14:0] a_t [3] = '{15'h4000, 15'h5FFF, 15'h6000};
        logic [15:0] d_t [3] = '{16'd4, 16'd3, 16'h0041};
        logic [15:0] e;
        kbd_code = 16'h0041;
        cpu_write(15'h4000, 16'd4);
        cpu_write(15'h5FFF, 16'd3);
        cpu_write(15'h6000, 16'd7);
        tests++;
        if (addr_err !== 1'b0) begin
            fail_kbd_err: begin
                fails++;
                $display("FAIL kbd_addr_err: addr_err=%b required 0", addr_err);
            end
        end
        for (int i = 0; i < 3; i++) begin
            addr = a_t[i];
            cq.push_back(d_t[i]);
            @(negedge clk);
            e = cq.pop_front();
            tests++;
            if (out !== e) begin
                fails++;
                $display("FAIL screen_kbd_read[%h]: out=%h required %h", a_t[i], out, e);
            end
            tick();
        end
        addr = 15'h4000;
        @(negedge clk);
        tests++;
        if (s_out !== 16'd4) begin
            fails++;
            $display("FAIL small_screen_read: out=%h required 0004", s_out);
        end
        tick();
    endtask

    task automatic test_out_of_range;
        logic [15:0] e;
        cpu_write(15'h0001, 16'h0055);
        addr = 15'h6001;
        in   = 16'd5;
        load = 1'b1;
        cq.push_back(16'h0000);
        @(negedge clk);
        e = cq.pop_front();
        tests++;
        if (out !== e) begin
            fails++;
            $display("FAIL oor_read: out=%h required %h", out, e);
        end
        tick();
        load = 1'b0;
        addr = 15'h0001;
        tests++;
        if (addr_err !== 1'b1 || s_addr_err !== 1'b1) begin
            fails++;
            $display("FAIL oor_err: addr_err=%b/%b required 1/1", addr_err, s_addr_err);
        end
        cq.push_back(16'h0055);
        @(negedge clk);
        e = cq.pop_front();
        tests++;
        if (out !== e) begin
            fails++;
            $display("FAIL oor_no_write: out=%h required %h", out, e);
        end
        tick();
        tests++;
        if (addr_err !== 1'b0) begin
            fails++;
            $display("FAIL oor_err_clear: addr_err=%b required 0", addr_err);
        end
    endtask

    task automatic test_backpressure;
        logic [9:0]  en_p = 10'b0100011111;
        logic [9:0]  rd_p = 10'b1110011011;
        logic [16:0] e, pv_d = '0;
        logic        pv_v = 1'b0, pv_r = 1'b0;
        for (int i = 0; i < 5; i++) cpu_write(15'(16'h4000 + i), 16'(10 + i));
        for (int i = 0; i < 5; i++) sq.push_back({i == 0, 16'(10 + i)});
        for (int k = 0; k < 10; k++) begin
            scan_en   = en_p[k];
            pix_ready = rd_p[k];
            @(negedge clk);
            if (pv_v && !pv_r) begin
                tests++;
                if (pix_valid !== 1'b1 || {pix_sof, pix_data} !== pv_d) begin
                    fails++;
                    $display("FAIL bp_hold[%0d]: valid=%b sof/data=%h required 1 %h", k, pix_valid, {pix_sof, pix_data}, pv_d);
                end
            end
            if (k == 8) begin
                tests++;
                if (pix_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_drain_idle: valid=%b required 0", pix_valid);
                end
            end
            if (pix_valid && pix_ready) begin
                tests++;
                if (sq.size() == 0) begin
                    fails++;
                    $display("FAIL bp_extra_beat: data=%h required no beat", pix_data);
                end else begin
                    e = sq.pop_front();
                    if ({pix_sof, pix_data} !== e) begin
                        fails++;
                        $display("FAIL bp_beat[%0d]: sof/data=%h required %h", k, {pix_sof, pix_data}, e);
                    end
                end
            end
            pv_v = pix_valid;
            pv_r = pix_ready;
            pv_d = {pix_sof, pix_data};
            tick();
        end
        scan_en   = 1'b0;
        pix_ready = 1'b0;
        tests++;
        if (sq.size() != 0) begin
            fails++;
            $display("FAIL bp_missing: %0d beats outstanding, required 0", sq.size());
            sq.delete();
        end
    endtask

    task automatic test_wrap;
        logic [16:0] e;
        for (int i = 0; i < 4; i++) cpu_write(15'(16'h4000 + i), 16'(20 + i));
        for (int i = 0; i < 6; i++) sq.push_back({(i % 4) == 0, 16'(20 + (i % 4))});
        for (int k = 0; k < 7; k++) begin
            s_scan_en   = (k < 6);
            s_pix_ready = 1'b1;
            @(negedge clk);
            if (s_pix_valid && s_pix_ready) begin
                tests++;
                if (sq.size() == 0) begin
                    fails++;
                    $display("FAIL wrap_extra_beat: data=%h required no beat", s_pix_data);
                end else begin
                    e = sq.pop_front();
                    if ({s_pix_sof, s_pix_data} !== e) begin
                        fails++;
                        $display("FAIL wrap_beat[%0d]: sof/data=%h required %h", k, {s_pix_sof, s_pix_data}, e);
                    end
                end
            end
            tick();
        end
        s_scan_en   = 1'b0;
        s_pix_ready = 1'b0;
        tests++;
        if (sq.size() != 0) begin
            fails++;
            $display("FAIL wrap_missing: %0d beats outstanding, required 0", sq.size());
            sq.delete();
        end
    endtask

    task automatic test_reset_mid_scan;
        logic [16:0] e;
        logic [15:0] c;
        cpu_write(15'h4005, 16'd25);
        scan_en   = 1'b1;
        pix_ready = 1'b0;
        tick();
        @(negedge clk);
        tests++;
        if (pix_valid !== 1'b1 || pix_data !== 16'd25) begin
            fails++;
            $display("FAIL mid_pending: valid=%b data=%h required 1 0019", pix_valid, pix_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        load  = 1'b1;
        addr  = 15'h0000;
        in    = 16'hDEAD;
        tick();
        reset     = 1'b0;
        load      = 1'b0;
        pix_ready = 1'b1;
        tests++;
        if (pix_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_valid: valid=%b required 0", pix_valid);
        end
        sq.push_back({1'b1, 16'd20});
        cq.push_back(16'd2);
        @(negedge clk);
        c = cq.pop_front();
        tests++;
        if (out !== c) begin
            fails++;
            $display("FAIL mid_ram_kept: out=%h required %h", out, c);
        end
        tick();
        scan_en = 1'b0;
        @(negedge clk);
        tests++;
        if (!(pix_valid && pix_ready)) begin
            fails++;
            $display("FAIL mid_first_beat: valid=%b required 1", pix_valid);
            sq.delete();
        end else begin
            e = sq.pop_front();
            if ({pix_sof, pix_data} !== e) begin
                fails++;
                $display("FAIL mid_first_word: sof/data=%h required %h", {pix_sof, pix_data}, e);
            end
        end
        tick();
        pix_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_screen_kbd();
        test_out_of_range();
        test_backpressure();
        test_wrap();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
